seq_detect_param: RTL
=====================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_LEN, 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, 4'b1011, target sequence; bit PAT_LEN-1 is the first bit received.
REQ-003 Parameter OVERLAP, 1, 1 = overlapping detection; 0 = non-overlapping detection.
REQ-004 Parameter CNT_W, 8, width of the match counter; legal range 1..32.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007 din  input  1  serial data bit.
REQ-008 din_valid  input  1  din is accepted on a rising edge only when din_valid=1.
REQ-009 clear  input  1  synchronous soft clear, active-high.
REQ-010 dout  output  1  registered one-cycle match pulse.
REQ-011 match_cnt  output  CNT_W  number of matches since reset or clear; saturates.
REQ-012 cnt_sat  output  1  high while match_cnt equals all-ones.

Function
REQ-013 Internal state: history register hist[PAT_LEN-1:0] and fill count fill (0..PAT_LEN, saturating) of valid bits held.
REQ-014 On an accepted bit: window = {hist[PAT_LEN-2:0], din}; fill_n = min(fill+1, PAT_LEN).
REQ-015 hit = (fill_n == PAT_LEN) and (window == PATTERN); partial windows never match.
REQ-016 On an accepted bit: hist <= window; dout <= hit.
REQ-017 dout rises on the edge that samples the final pattern bit and is high for exactly one cycle; latency is 0 cycles after that edge.
REQ-018 Cycles with din_valid=0 hold hist, fill and match_cnt; dout <= 0. Gaps never break a partial match.
REQ-019 OVERLAP=1: on hit, fill <= fill_n. A suffix of the matched bits can start the next match.
REQ-020 OVERLAP=0: on hit, fill <= 0. The next match needs PAT_LEN fresh accepted bits.
REQ-021 No hit: fill <= fill_n.
REQ-022 On hit with match_cnt below all-ones: match_cnt <= match_cnt+1. At all-ones, match_cnt holds and dout still pulses.
REQ-023 cnt_sat is combinationally (match_cnt == {CNT_W{1'b1}}).
REQ-024 clear=1: hist <= 0, fill <= 0, dout <= 0, match_cnt <= 0. The bit presented in that cycle is discarded, even if din_valid=1.
REQ-025 Priority: reset > clear > accepted bit.
REQ-026 Must synthesise for every legal PAT_LEN, PATTERN, OVERLAP and CNT_W combination without edits.

Reset
REQ-027 reset=0 at a rising edge: hist=0, fill=0, dout=0, match_cnt=0; cnt_sat=0 when CNT_W>=1.
REQ-028 A reset asserted mid-pattern discards all partial progress; detection restarts from an empty history.
REQ-029 During reset, din and din_valid are ignored; the first bit accepted is the one presented on the first edge with reset=1.

Verification
REQ-030 Defaults; accept bits 1,0,1,1 -> dout=1 for one cycle after the 4th bit edge; match_cnt=1.
REQ-031 OVERLAP=1; accept 1,0,1,1,0,1,1 -> dout pulses after bits 4 and 7; match_cnt=2.
REQ-032 OVERLAP=0; same stream -> one pulse, after bit 4 only; match_cnt=1.
REQ-033 PATTERN=4'b0000; after reset accept 0,0,0 -> dout=0; 4th 0 -> dout=1. Confirms fill gating.
REQ-034 Defaults; 1, gap(2 cycles), 0, 1, gap, 1 -> dout=1 after final bit; dout=0 during every gap cycle.
REQ-035 CNT_W=2, OVERLAP=1; 1011 then 011 four times (5 matches) -> match_cnt=3, cnt_sat=1, dout pulses 5 times. Then reset=0 mid-stream after 1,0,1 and accept 1 -> no pulse, match_cnt=0.

Source files
------------

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Purpose:
//   Serial pattern detector. It shifts accepted bits into a history window and
//   pulses dout for one cycle when the last PAT_LEN accepted bits equal
//   PATTERN. The first bit received is compared against bit PAT_LEN-1.
//   Detection can overlap or not, set by OVERLAP. A saturating counter tracks
//   the number of matches.
//
// Parameters:
//   PAT_LEN   pattern length in bits (2..16)
//   PATTERN   target sequence; MSB is the first bit received
//   OVERLAP   1 = a suffix of a match may begin the next one; 0 = fresh bits
//   CNT_W     width of the match counter (1..32)
//
// Ports:
//   clk        in   rising-edge clock for all state
//   reset      in   synchronous, active-low reset
//   din        in   serial data bit
//   din_valid  in   din is consumed only on edges where this is high
//   clear      in   synchronous soft clear, active-high; drops that cycle's bit
//   dout       out  registered one-cycle match pulse
//   match_cnt  out  matches since reset/clear, saturating at all-ones
//   cnt_sat    out  high while match_cnt is all-ones
// ---------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    // The fill count must be able to represent 0..PAT_LEN inclusive.
    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_dout;
    logic [CNT_W-1:0]   r_cnt;

    logic [PAT_LEN-1:0] w_window;
    logic [FILL_W-1:0]  w_fill_n;
    logic               w_hit;
    logic               w_cnt_full;

    always_comb begin
        w_window   = {r_hist[PAT_LEN-2:0], din};
        // The fill count saturates at PAT_LEN, so a long run of bits never wraps it.
        w_fill_n   = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
        // A window only counts once PAT_LEN real bits back it. Without this,
        // the zeroed history after reset could produce a false match.
        w_hit      = (w_fill_n == FILL_FULL) && (w_window == PATTERN);
        w_cnt_full = (r_cnt == {CNT_W{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_dout <= 1'b0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_hist <= '0;
            r_fill <= '0;
            r_dout <= 1'b0;
            r_cnt  <= '0;
        end else if (din_valid) begin
            r_hist <= w_window;
            r_dout <= w_hit;
            // In non-overlapping mode, a hit empties the window. The next match
            // then needs a full set of fresh bits.
            if (w_hit && (OVERLAP == 0))
                r_fill <= '0;
            else
                r_fill <= w_fill_n;
            if (w_hit && !w_cnt_full)
                r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            // An idle cycle keeps partial progress and only drops the pulse.
            r_dout <= 1'b0;
        end
    end

    assign dout      = r_dout;
    assign match_cnt = r_cnt;
    assign cnt_sat   = w_cnt_full;

endmodule
